// File: rtl/mac_sequencer.sv
// Multi-cycle MAC sequencer for the EX stage: iterative shift-add multiply,
// pipeline stall while in flight, then commit to the architectural accumulator.
module mac_sequencer #(
   parameter int XLEN = 32,
   parameter int BPC  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_e,
   input  logic            mac_valid_e,
   input  logic [1:0]      mac_op_e,
   input  logic [XLEN-1:0] src_a_e,
   input  logic [XLEN-1:0] src_b_e,
   output logic            stall_mac,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] acc_o
);

   // state | meaning
   // IDLE  | waiting for a MAC-class op in EX; CLR handled here in one cycle
   // BUSY  | N shift-add iterations, pipeline held
   // DONE  | result committed, done pulse, held instruction leaves EX
   localparam int N  = XLEN / BPC;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] mplier;
   logic [XLEN-1:0] partial;
   logic            op_mac;
   logic [CW-1:0]   cnt;

   logic            start;
   logic            clr;
   logic [XLEN-1:0] step;
   logic [XLEN-1:0] partial_nxt;

   assign start = (state == IDLE) & mac_valid_e & ~flush_e & ~mac_op_e[1];
   assign clr   = (state == IDLE) & mac_valid_e & ~flush_e & (mac_op_e == 2'b10);

   // Gated by rst so the hazard unit sees the stall drop the moment reset rises.
   assign stall_mac = ~rst & (start | (state == BUSY));

   always_comb begin
      step = '0;
      for (int i = 0; i < BPC; i++) begin
         if (mplier[i]) begin
            step = step + (mcand << i);
         end
      end
      partial_nxt = partial + step;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         mcand   <= '0;
         mplier  <= '0;
         partial <= '0;
         op_mac  <= 1'b0;
         cnt     <= '0;
         acc_o   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mcand   <= src_a_e;
                  mplier  <= src_b_e;
                  op_mac  <= mac_op_e[0];
                  partial <= '0;
                  cnt     <= CW'(N - 1);
                  busy    <= 1'b1;
                  state   <= BUSY;
               end else if (clr) begin
                  acc_o <= '0;
               end
            end
            BUSY: begin
               partial <= partial_nxt;
               mcand   <= mcand << BPC;
               mplier  <= mplier >> BPC;
               cnt     <= cnt - CW'(1);
               if (cnt == '0) begin
                  acc_o <= op_mac ? (acc_o + partial_nxt) : partial_nxt;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: two instances (BPC=1 and BPC=4) checked every cycle
// against an occupancy/arithmetic model, plus literal expectations from hand math.
module tb_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  v;
   logic [1:0]  fl;
   logic [1:0]  opc [2];
   logic [31:0] a   [2];
   logic [31:0] b   [2];
   logic [1:0]  stall_w;
   logic [1:0]  busy_w;
   logic [1:0]  done_w;
   logic [31:0] acc_w [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mac_sequencer #(.XLEN(32), .BPC(1)) dut0 (
      .clk(clk), .rst(rst), .flush_e(fl[0]), .mac_valid_e(v[0]), .mac_op_e(opc[0]),
      .src_a_e(a[0]), .src_b_e(b[0]), .stall_mac(stall_w[0]), .busy(busy_w[0]),
      .done(done_w[0]), .acc_o(acc_w[0])
   );

   mac_sequencer #(.XLEN(32), .BPC(4)) dut1 (
      .clk(clk), .rst(rst), .flush_e(fl[1]), .mac_valid_e(v[1]), .mac_op_e(opc[1]),
      .src_a_e(a[1]), .src_b_e(b[1]), .stall_mac(stall_w[1]), .busy(busy_w[1]),
      .done(done_w[1]), .acc_o(acc_w[1])
   );

   // Model: m_left counts the cycles an accepted op still occupies the unit
   // (N busy cycles then one done cycle); the result is plain a*b arithmetic.
   int          m_left [2];
   logic [31:0] m_acc  [2];
   logic [31:0] m_pend [2];

   function automatic logic starts(int d);
      return v[d] && !fl[d] && (opc[d] == 2'b00 || opc[d] == 2'b01);
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_left[d] <= 0;
            m_acc[d]  <= '0;
            m_pend[d] <= '0;
         end else if (m_left[d] == 0) begin
            if (starts(d)) begin
               m_left[d] <= ((d == 0) ? 32 : 8) + 1;
               m_pend[d] <= (opc[d] == 2'b00) ? a[d] * b[d] : m_acc[d] + a[d] * b[d];
            end else if (v[d] && !fl[d] && opc[d] == 2'b10) begin
               m_acc[d] <= '0;
            end
         end else begin
            m_left[d] <= m_left[d] - 1;
            if (m_left[d] == 2) m_acc[d] <= m_pend[d];
         end
      end
   end

   task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d actual=%0h required=%0h", nm, d, act, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic exp_stall;
         exp_stall = !rst && ((m_left[d] == 0 && starts(d)) || m_left[d] >= 2);
         chk("stall_mac", d, {31'b0, stall_w[d]}, {31'b0, exp_stall});
         chk("busy", d, {31'b0, busy_w[d]}, {31'b0, (m_left[d] >= 2)});
         chk("done", d, {31'b0, done_w[d]}, {31'b0, (m_left[d] == 1)});
         chk("acc_o", d, acc_w[d], m_acc[d]);
      end
   end

   // Present one instruction; hold it until done (or one cycle for non-multiply ops).
   task automatic run_op(input int d, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic f,
                         output int stalls, output int dcyc);
      @(posedge clk);
      #1;
      v[d] = 1'b1; opc[d] = o; a[d] = x; b[d] = y; fl[d] = f;
      stalls = 0;
      dcyc   = 0;
      if (!o[1] && !f) begin
         for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (stall_w[d]) stalls++;
            if (done_w[d]) begin
               dcyc = c;
               break;
            end
         end
         if (dcyc == 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout dut%0d actual=none required=pulse", d);
         end
      end else begin
         @(negedge clk);
         if (stall_w[d]) stalls++;
      end
   endtask

   task automatic idle(input int d);
      @(posedge clk);
      #1;
      v[d] = 1'b0; fl[d] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, dc;
      v = '0;
      fl = '0;
      for (int d = 0; d < 2; d++) begin
         opc[d] = 2'b00; a[d] = '0; b[d] = '0;
      end
      repeat (3) @(negedge clk);
      chk("reset_acc", 0, acc_w[0], 32'd0);
      chk("reset_stall", 0, {31'b0, stall_w[0]}, 32'd0);
      #2 rst = 1'b0;

      run_op(0, 2'b00, 32'd7, 32'd6, 1'b0, s, dc);
      chk("mul_stall_cycles", 0, s, 33);
      chk("mul_done_cycle", 0, dc, 34);
      chk("mul_acc", 0, acc_w[0], 32'd42);

      run_op(0, 2'b10, 32'd0, 32'd0, 1'b0, s, dc);
      chk("clr_stall", 0, s, 0);
      idle(0);
      chk("clr_acc", 0, acc_w[0], 32'd0);

      run_op(0, 2'b00, 32'd7, 32'd6, 1'b0, s, dc);
      chk("mul2_acc", 0, acc_w[0], 32'd42);
      run_op(0, 2'b01, 32'd3, 32'd5, 1'b0, s, dc);
      chk("mac_stall_cycles", 0, s, 33);
      chk("mac_acc", 0, acc_w[0], 32'd57);

      run_op(0, 2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0, s, dc);
      chk("mul_wrap_acc", 0, acc_w[0], 32'hFFFF_FFFE);
      run_op(0, 2'b01, 32'h8000_0000, 32'd2, 1'b0, s, dc);
      chk("mac_wrap_acc", 0, acc_w[0], 32'hFFFF_FFFE);

      run_op(0, 2'b00, 32'd5, 32'd5, 1'b1, s, dc);
      chk("flush_mul_stall", 0, s, 0);
      chk("flush_mul_busy", 0, {31'b0, busy_w[0]}, 32'd0);
      run_op(0, 2'b10, 32'd0, 32'd0, 1'b1, s, dc);
      chk("flush_clr_stall", 0, s, 0);
      idle(0);
      chk("flush_acc", 0, acc_w[0], 32'hFFFF_FFFE);

      @(posedge clk);
      #1;
      v[0] = 1'b1; opc[0] = 2'b00; a[0] = 32'd9; b[0] = 32'd9; fl[0] = 1'b0;
      repeat (11) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_stall", 0, {31'b0, stall_w[0]}, 32'd0);
      chk("rst_mid_busy", 0, {31'b0, busy_w[0]}, 32'd0);
      chk("rst_mid_acc", 0, acc_w[0], 32'd0);
      v[0] = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;

      run_op(0, 2'b00, 32'd2, 32'd3, 1'b0, s, dc);
      chk("post_rst_acc", 0, acc_w[0], 32'd6);
      idle(0);

      run_op(1, 2'b00, 32'd123, 32'd456, 1'b0, s, dc);
      chk("bpc4_stall_cycles", 1, s, 9);
      chk("bpc4_done_cycle", 1, dc, 10);
      chk("bpc4_acc", 1, acc_w[1], 32'd56088);
      run_op(1, 2'b11, 32'd1, 32'd1, 1'b0, s, dc);
      chk("rd_stall", 1, s, 0);
      idle(1);
      chk("rd_acc", 1, acc_w[1], 32'd56088);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
